// File: rtl/mux_key_rev_lookup.sv
// Reverse key lookup: scans a captured key/data table one entry per clock; hit at entry i answers
// after i+1 edges, a miss after NR_KEY. No new request while busy; response holds until resp_ready.
module mux_key_rev_lookup #(
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 2,
    parameter int DATA_LEN = 8,
    localparam int PL      = KEY_LEN + DATA_LEN,
    localparam int IDX_W   = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [DATA_LEN-1:0]      req_data,
    input  logic [NR_KEY*PL-1:0]     lut,
    input  logic [KEY_LEN-1:0]       default_key,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_hit,
    output logic [KEY_LEN-1:0]       resp_key,
    output logic [IDX_W-1:0]         resp_index
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_RESP
    } state_t;

    state_t                  r_state;
    logic                    r_req_ready;
    logic                    r_resp_valid;
    logic                    r_resp_hit;
    logic [KEY_LEN-1:0]      r_resp_key;
    logic [IDX_W-1:0]        r_resp_index;
    logic [IDX_W-1:0]        r_idx;
    logic [DATA_LEN-1:0]     r_req_data;
    logic [KEY_LEN-1:0]      r_dflt_key;
    logic [NR_KEY*PL-1:0]    r_lut;

    logic [PL-1:0]           w_entry;
    logic                    w_match;
    logic                    w_last;

    // The table is snapshotted at accept so later edits cannot disturb a search in flight.
    assign w_entry = r_lut[int'(r_idx)*PL +: PL];
    assign w_match = (w_entry[DATA_LEN-1:0] == r_req_data);
    assign w_last  = (r_idx == IDX_W'(NR_KEY-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_key   <= '0;
            r_resp_index <= '0;
            r_idx        <= '0;
            r_req_data   <= '0;
            r_dflt_key   <= '0;
            r_lut        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_req_ready && req_valid) begin
                        r_req_data  <= req_data;
                        r_lut       <= lut;
                        r_dflt_key  <= default_key;
                        r_idx       <= '0;
                        r_req_ready <= 1'b0;
                        r_state     <= S_SCAN;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_SCAN: begin
                    // Stopping at the first match gives lowest-index priority for duplicates.
                    if (w_match) begin
                        r_resp_valid <= 1'b1;
                        r_resp_hit   <= 1'b1;
                        r_resp_key   <= w_entry[PL-1:DATA_LEN];
                        r_resp_index <= r_idx;
                        r_state      <= S_RESP;
                    end else if (w_last) begin
                        r_resp_valid <= 1'b1;
                        r_resp_hit   <= 1'b0;
                        r_resp_key   <= r_dflt_key;
                        r_resp_index <= '0;
                        r_state      <= S_RESP;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_hit   = r_resp_hit;
    assign resp_key   = r_resp_key;
    assign resp_index = r_resp_index;

endmodule

// File: tb/tb_mux_key_rev_lookup.sv
// Directed bench for mux_key_rev_lookup with a 4-entry table containing a duplicate data value.
module tb_mux_key_rev_lookup;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_data;
    logic [39:0] lut;
    logic [1:0]  default_key;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_hit;
    logic [1:0]  resp_key;
    logic [1:0]  resp_index;

    int checks = 0;
    int errors = 0;

    localparam logic [39:0] LUT_BASE = {2'd3, 8'hA0, 2'd2, 8'h55, 2'd1, 8'h55, 2'd0, 8'h10};

    mux_key_rev_lookup #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .lut         (lut),
        .default_key (default_key),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_hit    (resp_hit),
        .resp_key    (resp_key),
        .resp_index  (resp_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits (bounded) for req_ready, then presents one request for exactly the accept edge.
    task automatic send_req(input logic [7:0] data);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_req_ready: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1;
        req_data  = data;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until resp_valid; -1 if it never comes.
    task automatic wait_resp(output int lat);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (resp_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic ack_resp();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_hit, resp_key, resp_index} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b hit=%b key=%0d idx=%0d required all 0",
                     req_ready, resp_valid, resp_hit, resp_key, resp_index);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: req_ready=%b required 1", req_ready);
        end
    endtask

    task automatic test_first_entry();
        int lat;
        send_req(8'h10);
        wait_resp(lat);
        checks++;
        if (lat !== 1 || resp_hit !== 1'b1 || resp_key !== 2'd0 || resp_index !== 2'd0) begin
            errors++;
            $display("FAIL first_entry: lat=%0d hit=%b key=%0d idx=%0d required lat=1 hit=1 key=0 idx=0",
                     lat, resp_hit, resp_key, resp_index);
        end
        ack_resp();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL first_entry_ack: vld=%b rdy=%b required vld=0 rdy=1", resp_valid, req_ready);
        end
    endtask

    task automatic test_duplicate();
        int lat;
        send_req(8'h55);
        wait_resp(lat);
        checks++;
        if (lat !== 2 || resp_hit !== 1'b1 || resp_key !== 2'd1 || resp_index !== 2'd1) begin
            errors++;
            $display("FAIL duplicate: lat=%0d hit=%b key=%0d idx=%0d required lat=2 hit=1 key=1 idx=1",
                     lat, resp_hit, resp_key, resp_index);
        end
        ack_resp();
    endtask

    task automatic test_last_and_miss();
        int lat;
        send_req(8'hA0);
        wait_resp(lat);
        checks++;
        if (lat !== 4 || resp_hit !== 1'b1 || resp_key !== 2'd3 || resp_index !== 2'd3) begin
            errors++;
            $display("FAIL last_entry: lat=%0d hit=%b key=%0d idx=%0d required lat=4 hit=1 key=3 idx=3",
                     lat, resp_hit, resp_key, resp_index);
        end
        ack_resp();
        checks++;
        if (resp_hit !== 1'b1 || resp_key !== 2'd3 || resp_index !== 2'd3) begin
            errors++;
            $display("FAIL hold_after_ack: hit=%b key=%0d idx=%0d required hit=1 key=3 idx=3",
                     resp_hit, resp_key, resp_index);
        end
        send_req(8'h77);
        wait_resp(lat);
        checks++;
        if (lat !== 4 || resp_hit !== 1'b0 || resp_key !== 2'd3 || resp_index !== 2'd0) begin
            errors++;
            $display("FAIL miss: lat=%0d hit=%b key=%0d idx=%0d required lat=4 hit=0 key=3 idx=0",
                     lat, resp_hit, resp_key, resp_index);
        end
        ack_resp();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        send_req(8'h55);
        wait_resp(lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL bp_latency: lat=%0d required 2", lat);
        end
        // A request presented while busy must be ignored.
        req_valid = 1'b1;
        req_data  = 8'h10;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp_hit !== 1'b1 || resp_key !== 2'd1 ||
                resp_index !== 2'd1 || req_ready !== 1'b0)
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_hold: unstable cycles=%0d required 0 (vld=%b key=%0d idx=%0d rdy=%b)",
                     bad, resp_valid, resp_key, resp_index, req_ready);
        end
        req_valid = 1'b0;
        ack_resp();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: vld=%b rdy=%b required vld=0 rdy=1", resp_valid, req_ready);
        end
    endtask

    task automatic test_lut_change();
        int lat;
        send_req(8'hA0);
        lut[37:30] = 8'h00;
        default_key = 2'd0;
        wait_resp(lat);
        checks++;
        if (lat !== 4 || resp_hit !== 1'b1 || resp_key !== 2'd3 || resp_index !== 2'd3) begin
            errors++;
            $display("FAIL lut_change: lat=%0d hit=%b key=%0d idx=%0d required lat=4 hit=1 key=3 idx=3",
                     lat, resp_hit, resp_key, resp_index);
        end
        ack_resp();
        lut = LUT_BASE;
        default_key = 2'd3;
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen;
        send_req(8'hA0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0 || resp_key !== 2'd0) begin
            errors++;
            $display("FAIL abort_immediate: vld=%b rdy=%b key=%0d required 0 0 0",
                     resp_valid, req_ready, resp_key);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (resp_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_resp: resp_valid cycles=%0d required 0", seen);
        end
        send_req(8'h10);
        wait_resp(lat);
        checks++;
        if (lat !== 1 || resp_hit !== 1'b1 || resp_key !== 2'd0 || resp_index !== 2'd0) begin
            errors++;
            $display("FAIL after_abort: lat=%0d hit=%b key=%0d idx=%0d required lat=1 hit=1 key=0 idx=0",
                     lat, resp_hit, resp_key, resp_index);
        end
        ack_resp();
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_data    = 8'h00;
        resp_ready  = 1'b0;
        lut         = LUT_BASE;
        default_key = 2'd3;
        test_reset();
        test_first_entry();
        test_duplicate();
        test_last_and_miss();
        test_backpressure();
        test_lut_change();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
